// File: rtl/cachebus_arbiter_pkg.sv
// Shared types for the cache line-burst bus arbiter.
package cachebus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } arbstate_t;

  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b10;
  localparam logic [1:0] RW_WRITE = 2'b01;

endpackage

// File: rtl/cachebus_arbiter_rr_arb2.sv
// Two-way round-robin grant between the I$ and D$; the side that did not win last time wins a tie.
module cachebus_arbiter_rr_arb2 (
  input  logic       ReqI,
  input  logic       ReqD,
  input  logic       LastD,
  output logic [1:0] Grant
);

  // Grant[1] selects the D$, Grant[0] the I$.
  assign Grant[1] = ReqD & (~ReqI | ~LastD);
  assign Grant[0] = ReqI & (~ReqD | LastD);

endmodule

// File: rtl/cachebus_arbiter.sv
// Shares the line-burst bus between I$ and D$, holding it for the owner until the last beat is accepted.
module cachebus_arbiter #(
  parameter int PA_BITS = 56,
  parameter int LOGBWPL = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               IReq,
  input  logic [PA_BITS-1:0] IAdr,
  output logic               IAck,
  input  logic [1:0]         DRW,
  input  logic [PA_BITS-1:0] DAdr,
  output logic               DAck,
  input  logic               BusReady,
  output logic [1:0]         BusRW,
  output logic [PA_BITS-1:0] BusAdr,
  output logic [LOGBWPL-1:0] BeatCount,
  output logic               OwnerD,
  output logic               Busy
);

  import cachebus_arbiter_pkg::*;

  localparam int BEATSPERLINE = 2**LOGBWPL;
  localparam logic [LOGBWPL-1:0] LASTBEAT = LOGBWPL'(BEATSPERLINE - 1);

  arbstate_t          r_state, w_stateNext;
  logic [LOGBWPL-1:0] r_beatCount, w_beatNext;
  logic               r_ownerD, w_ownerNext;
  logic               r_lastD, w_lastDNext;
  logic               w_reqD;
  logic [1:0]         w_grant;
  logic [1:0]         w_ownerRW;

  assign w_reqD = |DRW;

  cachebus_arbiter_rr_arb2 u_rr (
    .ReqI  (IReq),
    .ReqD  (w_reqD),
    .LastD (r_lastD),
    .Grant (w_grant)
  );

  // An illegal DRW of 11 is forwarded as a plain writeback.
  assign w_ownerRW = r_ownerD ? ((DRW == 2'b11) ? RW_WRITE : DRW)
                              : (IReq ? RW_READ : RW_NONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_beatCount <= '0;
      r_ownerD    <= 1'b0;
      r_lastD     <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_beatCount <= w_beatNext;
      r_ownerD    <= w_ownerNext;
      r_lastD     <= w_lastDNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_beatNext  = r_beatCount;
    w_ownerNext = r_ownerD;
    w_lastDNext = r_lastD;
    BusRW       = RW_NONE;
    BusAdr      = '0;
    IAck        = 1'b0;
    DAck        = 1'b0;
    Busy        = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_grant) begin
          w_ownerNext = w_grant[1];
          w_beatNext  = '0;
          w_stateNext = XFER;
        end
      end
      XFER: begin
        Busy   = 1'b1;
        BusRW  = w_ownerRW;
        BusAdr = r_ownerD ? DAdr : IAdr;
        if (BusReady) begin
          w_beatNext = r_beatCount + 1'b1;
          if (r_beatCount == LASTBEAT) w_stateNext = DONE;
        end
      end
      DONE: begin
        Busy        = 1'b1;
        IAck        = ~r_ownerD;
        DAck        = r_ownerD;
        w_lastDNext = r_ownerD;
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign BeatCount = r_beatCount;
  assign OwnerD    = r_ownerD;

  a_legalDrw: assert property (@(posedge clk) disable iff (reset) DRW != 2'b11);

  // The owner must keep its request up for the whole burst.
  a_ownerHolds: assert property (@(posedge clk) disable iff (reset)
    (r_state == XFER) |-> (r_ownerD ? w_reqD : IReq));

endmodule

// File: doc/cachebus_arbiter.md
Name: cachebus_arbiter

Overview:
- Shares the single line-burst bus interface between the I$ and D$ cache controllers.
- Picks one requester per line transaction using round-robin, and locks the bus to that requester until the last beat is accepted.
- Drives the shared bus command, address, beat counter and owner select, then returns a one-cycle ack to the owner.
- Sits between the two cache instances and the AHB cache-interface burst logic.

Parameters:
- PA_BITS, 56, physical address width.
- LOGBWPL, 3, log2 of beats per cache line (8 beats by default).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- IReq  in  1  I$ line-fetch request (I$ CacheBusRW[1]).
- IAdr  in  PA_BITS  I$ line address, offset bits zero.
- IAck  out  1  I$ transaction complete, one-cycle pulse.
- DRW  in  2  D$ CacheBusRW: [1] fetch, [0] writeback.
- DAdr  in  PA_BITS  D$ line address.
- DAck  out  1  D$ transaction complete, one-cycle pulse.
- BusReady  in  1  bus accepted/returned the current beat.
- BusRW  out  2  shared bus command: [1] read burst, [0] write burst.
- BusAdr  out  PA_BITS  shared bus line address.
- BeatCount  out  LOGBWPL  current beat index within the burst.
- OwnerD  out  1  1 = D$ owns the bus (steers write-data and FetchBuffer muxes).
- Busy  out  1  a transaction is in progress.

Behaviour:
- Reset is asynchronous and active-high; there is one clock, clk.
- Reset values:
  - State = IDLE; BeatCount = 0; OwnerD = 0; LastD = 0.
  - BusRW = 00; BusAdr = 0; IAck = DAck = 0; Busy = 0.
- Request validity:
  - D request = |DRW. DRW = 11 is illegal (simulation assertion); it is treated as a writeback.
  - I request = IReq.
- States:
  - IDLE: no requests → stay.
    - Exactly one request → register that owner and go to XFER next cycle.
    - Both requesting → winner is the opposite of LastD (round-robin); D wins on the first conflict after reset.
  - XFER:
    - Busy = 1.
    - BusRW = the owner's live request (I: 10; D: DRW).
    - BusAdr = the owner's address.
    - On each BusReady, BeatCount increments.
    - BusReady with BeatCount == 2^LOGBWPL-1 → go to DONE; BeatCount wraps to 0.
  - DONE (one cycle):
    - Owner's ack = 1; BusRW = 00; Busy = 1.
    - LastD ← OwnerD.
    - Go to IDLE.
- Latency: request in IDLE at cycle N → BusRW valid at N+1 → ack at the cycle after the last BusReady. Minimum is 2^LOGBWPL+2 cycles.
- Handshake:
  - A requester may withdraw its request before it is granted (e.g. FlushStage); no effect.
  - After the grant it must hold the request and address stable until ack. Withdrawal in XFER is a protocol violation: the burst still completes and ack is still issued (simulation assertion).
- After ack, a request seen in IDLE is treated as a new transaction. Requesters drop their request in the ack cycle.
- The non-owner's request in XFER/DONE is ignored, never lost. It is re-arbitrated in IDLE.
- Simultaneous events:
  - BusReady in IDLE or DONE is ignored.
  - A new request arriving during DONE waits for IDLE; there is no back-to-back grant, so the bus always has one idle cycle.
- Reset mid-burst: immediate return to IDLE. No ack is issued; partial beats are discarded.
- BeatCount arithmetic is modulo 2^LOGBWPL, unsigned.

Decomposition:
- Shared package cvw (existing): add enum arbstate_t {IDLE, XFER, DONE}.
- Add localparam BEATSPERLINE = 2**LOGBWPL.
- One natural sub-module: rr_arb2, the 2-way round-robin grant (inputs ReqI, ReqD, LastD; one-hot output). Counter and muxes stay inline.

Test Plan:
- Reset mid-burst:
  - Stimulus: assert reset during XFER at beat 3.
  - Required response: all outputs go to 0 immediately; with no requests, IDLE is held; no ack is issued.
- Lone I$ fetch:
  - Stimulus: IReq=1, IAdr=0x80001000, BusReady held 1.
  - Required response: BusRW=10 and BusAdr=0x80001000 one cycle later; BeatCount runs 0..7; IAck pulses exactly once at cycle 10; OwnerD=0.
- D$ writeback with stalls:
  - Stimulus: DRW=01, DAdr=0x80002040; BusReady low every other cycle.
  - Required response: BusRW=01; BeatCount advances only on BusReady; DAck pulses after the 8th ready.
- Simultaneous requests, repeated:
  - Stimulus: IReq=1 and DRW=10 both asserted; requesters drop on ack and reassert.
  - Required response: grant order is D, I, D, I; OwnerD toggles; no ack is missed.
- Withdrawal before grant:
  - Stimulus: DRW=10 during an I$ burst; DRW drops before IDLE.
  - Required response: no D grant; the arbiter returns to IDLE with Busy=0.
